// File: rtl/br_rs_sched_if.sv
// br_rs_sched_if: dispatch, CDB and issue signals between rename, the branch RS and the branch FU
interface br_rs_sched_if #(
  parameter int ROB_W = 5
);
  logic             disp_valid;
  logic             disp_ready;
  logic [ROB_W-1:0] disp_rob_tag;
  logic [1:0]       disp_bj;
  logic [2:0]       disp_br_op;
  logic [31:0]      disp_pc;
  logic [31:0]      disp_offset;
  logic             disp_br_pred;
  logic             disp_rs1_rdy;
  logic             disp_rs2_rdy;
  logic [ROB_W-1:0] disp_rs1_tag;
  logic [ROB_W-1:0] disp_rs2_tag;
  logic [31:0]      disp_rs1_v;
  logic [31:0]      disp_rs2_v;
  logic             cdb_valid;
  logic [ROB_W-1:0] cdb_rob_tag;
  logic [31:0]      cdb_data;
  logic             iss_valid;
  logic             iss_ready;
  logic [ROB_W-1:0] iss_rob_tag;
  logic [1:0]       iss_bj;
  logic [2:0]       iss_br_op;
  logic [31:0]      iss_pc;
  logic [31:0]      iss_offset;
  logic             iss_br_pred;
  logic [31:0]      iss_rs1_v;
  logic [31:0]      iss_rs2_v;
  modport master (
    output disp_valid, disp_rob_tag, disp_bj, disp_br_op, disp_pc, disp_offset, disp_br_pred,
           disp_rs1_rdy, disp_rs2_rdy, disp_rs1_tag, disp_rs2_tag, disp_rs1_v, disp_rs2_v,
           cdb_valid, cdb_rob_tag, cdb_data, iss_ready,
    input  disp_ready, iss_valid, iss_rob_tag, iss_bj, iss_br_op, iss_pc, iss_offset,
           iss_br_pred, iss_rs1_v, iss_rs2_v
  );
  modport slave (
    input  disp_valid, disp_rob_tag, disp_bj, disp_br_op, disp_pc, disp_offset, disp_br_pred,
           disp_rs1_rdy, disp_rs2_rdy, disp_rs1_tag, disp_rs2_tag, disp_rs1_v, disp_rs2_v,
           cdb_valid, cdb_rob_tag, cdb_data, iss_ready,
    output disp_ready, iss_valid, iss_rob_tag, iss_bj, iss_br_op, iss_pc, iss_offset,
           iss_br_pred, iss_rs1_v, iss_rs2_v
  );
endinterface

// File: rtl/br_rs_sched.sv
// br_rs_sched: branch/jump reservation station issuing the oldest ready op by ROB age
// Define BR_SCHED_PERF_EN to build the issue/full performance counters.
module br_rs_sched #(
  parameter int DEPTH = 4,
  parameter int ROB_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [ROB_W-1:0] rob_head,
  br_rs_sched_if.slave     bus,
  output logic [31:0]      perf_issue_cnt,
  output logic [31:0]      perf_full_cnt
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef struct packed {
    logic [ROB_W-1:0] tag;
    logic [1:0]       bj;
    logic [2:0]       br_op;
    logic [31:0]      pc;
    logic [31:0]      offset;
    logic             pred;
    logic             r1;
    logic             r2;
    logic [ROB_W-1:0] t1;
    logic [ROB_W-1:0] t2;
    logic [31:0]      v1;
    logic [31:0]      v2;
  } ent_t;
  ent_t             ent [DEPTH];
  ent_t             disp_ent;
  logic [DEPTH-1:0] vld;
  logic [IW-1:0]    free_idx;
  logic [IW-1:0]    sel_idx;
  logic [ROB_W-1:0] age;
  logic [ROB_W-1:0] best_age;
  logic             cand;
  logic             load;
  logic             disp_fire;
  assign bus.disp_ready = ~&vld;
  assign disp_fire = bus.disp_valid && bus.disp_ready && bus.disp_bj != 2'b00;
  assign load = cand && (!bus.iss_valid || bus.iss_ready);
  // operands produced on the CDB in the dispatch cycle are captured on the way in
  assign disp_ent = '{
    tag:    bus.disp_rob_tag,
    bj:     bus.disp_bj,
    br_op:  bus.disp_br_op,
    pc:     bus.disp_pc,
    offset: bus.disp_offset,
    pred:   bus.disp_br_pred,
    r1:     bus.disp_rs1_rdy || (bus.cdb_valid && bus.cdb_rob_tag == bus.disp_rs1_tag),
    r2:     bus.disp_rs2_rdy || (bus.cdb_valid && bus.cdb_rob_tag == bus.disp_rs2_tag),
    t1:     bus.disp_rs1_tag,
    t2:     bus.disp_rs2_tag,
    v1:     bus.disp_rs1_rdy ? bus.disp_rs1_v : bus.cdb_data,
    v2:     bus.disp_rs2_rdy ? bus.disp_rs2_v : bus.cdb_data
  };
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) free_idx = vld[i] ? free_idx : IW'(i);
  end
  // age relative to rob_head makes the compare safe across tag wrap-around
  always_comb begin
    cand = 1'b0;
    sel_idx = '0;
    best_age = '0;
    age = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age = ent[i].tag - rob_head;
      if (vld[i] && ent[i].r1 && ent[i].r2 && (!cand || age < best_age)) begin
        cand = 1'b1;
        sel_idx = IW'(i);
        best_age = age;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n || flush) vld <= '0;
    else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (vld[i] && bus.cdb_valid && !ent[i].r1 && ent[i].t1 == bus.cdb_rob_tag) begin
          ent[i].r1 <= 1'b1;
          ent[i].v1 <= bus.cdb_data;
        end
        if (vld[i] && bus.cdb_valid && !ent[i].r2 && ent[i].t2 == bus.cdb_rob_tag) begin
          ent[i].r2 <= 1'b1;
          ent[i].v2 <= bus.cdb_data;
        end
      end
      if (load) vld[sel_idx] <= 1'b0;
      if (disp_fire) begin
        vld[free_idx] <= 1'b1;
        ent[free_idx] <= disp_ent;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.iss_valid   <= 1'b0;
      bus.iss_rob_tag <= '0;
      bus.iss_bj      <= '0;
      bus.iss_br_op   <= '0;
      bus.iss_pc      <= '0;
      bus.iss_offset  <= '0;
      bus.iss_br_pred <= 1'b0;
      bus.iss_rs1_v   <= '0;
      bus.iss_rs2_v   <= '0;
    end else if (flush) bus.iss_valid <= 1'b0;
    else if (load) begin
      bus.iss_valid   <= 1'b1;
      bus.iss_rob_tag <= ent[sel_idx].tag;
      bus.iss_bj      <= ent[sel_idx].bj;
      bus.iss_br_op   <= ent[sel_idx].br_op;
      bus.iss_pc      <= ent[sel_idx].pc;
      bus.iss_offset  <= ent[sel_idx].offset;
      bus.iss_br_pred <= ent[sel_idx].pred;
      bus.iss_rs1_v   <= ent[sel_idx].v1;
      bus.iss_rs2_v   <= ent[sel_idx].v2;
    end else if (bus.iss_ready) bus.iss_valid <= 1'b0;
  end
`ifdef BR_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_issue_cnt <= '0;
      perf_full_cnt  <= '0;
    end else begin
      if (load && !flush) perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if (bus.disp_valid && !bus.disp_ready) perf_full_cnt <= perf_full_cnt + 32'd1;
    end
  end
`else
  assign perf_issue_cnt = '0;
  assign perf_full_cnt  = '0;
`endif
endmodule

// File: tb/tb_br_rs_sched.sv
// tb_br_rs_sched: directed stimulus checked each cycle against a queue-based RS model
module tb_br_rs_sched;
  localparam int DEPTH = 4;
  localparam int ROB_W = 5;
`ifdef BR_SCHED_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic [ROB_W-1:0] rob_head = '0;
  logic [31:0]      perf_issue_cnt;
  logic [31:0]      perf_full_cnt;
  br_rs_sched_if #(.ROB_W(ROB_W)) bus ();
  br_rs_sched #(.DEPTH(DEPTH), .ROB_W(ROB_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .rob_head(rob_head), .bus(bus),
    .perf_issue_cnt(perf_issue_cnt), .perf_full_cnt(perf_full_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [ROB_W-1:0] tag;
    logic [1:0]       bj;
    logic [2:0]       op;
    logic [31:0]      pc;
    logic [31:0]      off;
    logic             pred;
    logic             r1;
    logic             r2;
    logic [ROB_W-1:0] t1;
    logic [ROB_W-1:0] t2;
    logic [31:0]      v1;
    logic [31:0]      v2;
  } op_t;
  op_t         rs_q[$];
  op_t         m_iss;
  bit          m_iv;
  int unsigned m_pi;
  int unsigned m_pf;
  bit          chk_en;
  int          checks;
  int          failures;
  function void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction
  // model: an unordered bag of waiting ops, oldest ready one leaves at each edge it can
  always @(posedge clk) begin : model
    int best;
    logic [ROB_W-1:0] a;
    logic [ROB_W-1:0] ba;
    bit full;
    op_t n;
    if (!rst_n) begin
      rs_q.delete();
      m_iv = 0;
      m_pi = 0;
      m_pf = 0;
    end else begin
      full = rs_q.size() == DEPTH;
      if (bus.disp_valid && full) m_pf++;
      if (flush) begin
        rs_q.delete();
        m_iv = 0;
      end else begin
        best = -1;
        ba = '0;
        foreach (rs_q[i]) if (rs_q[i].r1 && rs_q[i].r2) begin
          a = rs_q[i].tag - rob_head;
          if (best < 0 || a < ba) begin
            best = i;
            ba = a;
          end
        end
        if (best >= 0 && (!m_iv || bus.iss_ready)) begin
          m_iss = rs_q[best];
          m_iv = 1;
          rs_q.delete(best);
          m_pi++;
        end else if (bus.iss_ready) m_iv = 0;
        if (bus.cdb_valid) foreach (rs_q[i]) begin
          if (!rs_q[i].r1 && rs_q[i].t1 == bus.cdb_rob_tag) begin rs_q[i].r1 = 1; rs_q[i].v1 = bus.cdb_data; end
          if (!rs_q[i].r2 && rs_q[i].t2 == bus.cdb_rob_tag) begin rs_q[i].r2 = 1; rs_q[i].v2 = bus.cdb_data; end
        end
        if (bus.disp_valid && !full && bus.disp_bj != 2'b00) begin
          n.tag = bus.disp_rob_tag; n.bj = bus.disp_bj; n.op = bus.disp_br_op;
          n.pc = bus.disp_pc; n.off = bus.disp_offset; n.pred = bus.disp_br_pred;
          n.t1 = bus.disp_rs1_tag; n.t2 = bus.disp_rs2_tag;
          n.r1 = bus.disp_rs1_rdy; n.v1 = bus.disp_rs1_v;
          n.r2 = bus.disp_rs2_rdy; n.v2 = bus.disp_rs2_v;
          if (!n.r1 && bus.cdb_valid && bus.cdb_rob_tag == n.t1) begin n.r1 = 1; n.v1 = bus.cdb_data; end
          if (!n.r2 && bus.cdb_valid && bus.cdb_rob_tag == n.t2) begin n.r2 = 1; n.v2 = bus.cdb_data; end
          rs_q.push_back(n);
        end
      end
    end
  end
  always @(negedge clk) if (chk_en) begin
    chk("disp_ready", bus.disp_ready, rs_q.size() < DEPTH);
    chk("iss_valid", bus.iss_valid, m_iv);
    if (m_iv) begin
      chk("iss_rob_tag", bus.iss_rob_tag, m_iss.tag);
      chk("iss_bj", bus.iss_bj, m_iss.bj);
      chk("iss_br_op", bus.iss_br_op, m_iss.op);
      chk("iss_pc", bus.iss_pc, m_iss.pc);
      chk("iss_offset", bus.iss_offset, m_iss.off);
      chk("iss_br_pred", bus.iss_br_pred, m_iss.pred);
      chk("iss_rs1_v", bus.iss_rs1_v, m_iss.v1);
      chk("iss_rs2_v", bus.iss_rs2_v, m_iss.v2);
    end
    chk("perf_issue_cnt", perf_issue_cnt, PERF ? m_pi : 0);
    chk("perf_full_cnt", perf_full_cnt, PERF ? m_pf : 0);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.disp_valid = 0;
    bus.cdb_valid = 0;
  endtask
  task automatic disp(input logic [ROB_W-1:0] tag, input logic [1:0] bj,
                      input logic r1, input logic [ROB_W-1:0] t1, input logic [31:0] v1,
                      input logic r2, input logic [ROB_W-1:0] t2, input logic [31:0] v2);
    logic [31:0] tw;
    tw = 32'(tag);
    bus.disp_valid = 1; bus.disp_rob_tag = tag; bus.disp_bj = bj;
    bus.disp_br_op = tw[2:0]; bus.disp_pc = 32'h1000 + tw * 4; bus.disp_offset = 32'h10 + tw;
    bus.disp_br_pred = tw[0];
    bus.disp_rs1_rdy = r1; bus.disp_rs1_tag = t1; bus.disp_rs1_v = v1;
    bus.disp_rs2_rdy = r2; bus.disp_rs2_tag = t2; bus.disp_rs2_v = v2;
  endtask
  task automatic cdb(input logic [ROB_W-1:0] tag, input logic [31:0] data);
    bus.cdb_valid = 1; bus.cdb_rob_tag = tag; bus.cdb_data = data;
  endtask
  initial begin
    idle();
    disp(0, 0, 0, 0, 0, 0, 0, 0);
    bus.disp_valid = 0;
    bus.cdb_rob_tag = 0; bus.cdb_data = 0;
    bus.iss_ready = 1;
    tick(); tick();
    chk_en = 1;
    chk("rst_iss_valid", bus.iss_valid, 0);
    chk("rst_disp_ready", bus.disp_ready, 1);
    chk("rst_iss_pc", bus.iss_pc, 0);
    chk("rst_perf_issue", perf_issue_cnt, 0);
    chk("rst_perf_full", perf_full_cnt, 0);
    rst_n = 1;
    tick();
    // ready op issues two cycles after dispatch
    disp(3, 1, 1, 0, 5, 1, 0, 5); tick(); idle();
    chk("t1_n1_valid", bus.iss_valid, 0); tick();
    chk("t1_valid", bus.iss_valid, 1);
    chk("t1_tag", bus.iss_rob_tag, 3);
    chk("t1_rs1", bus.iss_rs1_v, 5);
    chk("t1_rs2", bus.iss_rs2_v, 5); tick();
    chk("t1_drop", bus.iss_valid, 0);
    // CDB wakeup then issue two cycles later
    disp(4, 1, 0, 2, 0, 1, 0, 7); tick(); idle();
    cdb(2, 32'h40); tick(); idle();
    chk("t2_c1_valid", bus.iss_valid, 0); tick();
    chk("t2_valid", bus.iss_valid, 1);
    chk("t2_tag", bus.iss_rob_tag, 4);
    chk("t2_rs1", bus.iss_rs1_v, 32'h40); tick();
    // wrap-around age: head 30, tag 31 older than tag 1
    rob_head = 30;
    disp(1, 2, 0, 20, 0, 1, 0, 11); tick();
    disp(31, 3, 1, 0, 12, 0, 20, 0); tick(); idle();
    cdb(20, 9); tick(); idle(); tick();
    chk("t3_first", bus.iss_rob_tag, 31);
    chk("t3_first_rs2", bus.iss_rs2_v, 9); tick();
    chk("t3_second", bus.iss_rob_tag, 1);
    chk("t3_second_v", bus.iss_valid, 1);
    chk("t3_second_rs1", bus.iss_rs1_v, 9); tick();
    chk("t3_empty", bus.iss_valid, 0);
    chk("t3_perf_issue", perf_issue_cnt, PERF ? 4 : 0);
    rob_head = 0;
    // fill, drop extra dispatch, wake one
    disp(5, 1, 0, 10, 0, 1, 0, 1); tick();
    disp(6, 1, 0, 11, 0, 1, 0, 2); tick();
    disp(7, 1, 0, 12, 0, 1, 0, 3); tick();
    disp(8, 1, 0, 13, 0, 1, 0, 4); tick();
    chk("t4_full", bus.disp_ready, 0);
    disp(9, 1, 1, 0, 1, 1, 0, 1); tick();
    chk("t4_full2", bus.disp_ready, 0); tick(); idle();
    chk("t4_perf_full", perf_full_cnt, PERF ? 2 : 0);
    cdb(10, 32'h77); tick(); idle();
    chk("t4_still_full", bus.disp_ready, 0); tick();
    chk("t4_freed", bus.disp_ready, 1);
    chk("t4_tag", bus.iss_rob_tag, 5);
    chk("t4_rs1", bus.iss_rs1_v, 32'h77);
    cdb(11, 32'h111); tick();
    cdb(12, 32'h222); tick();
    cdb(13, 32'h333); tick(); idle();
    repeat (4) tick();
    chk("t4_drained", bus.iss_valid, 0);
    // backpressure holds the issue register
    bus.iss_ready = 0;
    disp(2, 1, 1, 0, 21, 1, 0, 22); tick();
    disp(3, 1, 1, 0, 31, 1, 0, 32); tick(); idle();
    chk("t5_hold0", bus.iss_rob_tag, 2); tick();
    chk("t5_hold1", bus.iss_rob_tag, 2);
    chk("t5_hold1_rs1", bus.iss_rs1_v, 21); tick();
    chk("t5_hold2", bus.iss_rob_tag, 2);
    bus.iss_ready = 1; tick();
    chk("t5_next", bus.iss_rob_tag, 3);
    chk("t5_next_v", bus.iss_valid, 1); tick();
    chk("t5_done", bus.iss_valid, 0);
    // flush kills RS, issue reg and the concurrent dispatch
    bus.iss_ready = 0;
    disp(4, 1, 1, 0, 1, 1, 0, 2); tick();
    disp(5, 1, 0, 20, 0, 1, 0, 3); tick();
    disp(6, 1, 0, 20, 0, 1, 0, 4); tick();
    disp(7, 1, 0, 20, 0, 1, 0, 5); tick();
    chk("t6_pre_valid", bus.iss_valid, 1);
    chk("t6_pre_ready", bus.disp_ready, 1);
    flush = 1;
    disp(8, 1, 1, 0, 6, 1, 0, 7);
    cdb(20, 32'h99); tick();
    flush = 0; idle();
    chk("t6_valid", bus.iss_valid, 0);
    chk("t6_ready", bus.disp_ready, 1);
    bus.iss_ready = 1;
    cdb(20, 32'h99); tick(); idle();
    repeat (3) begin
      tick();
      chk("t6_no_issue", bus.iss_valid, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
